// File: rtl/quad_enc_decoder.sv
// Quadrature encoder front end: synchronizes and filters A/B/index, then decodes
// Gray-code steps into registered count-enable, direction, index-clear and error outputs.
module quad_enc_decoder #(
   parameter int unsigned StableN = 4
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic a_i,
   input  logic b_i,
   input  logic idx_i,
   input  logic en_idx_i,
   input  logic err_clr_i,
   output logic en_o,
   output logic up_o,
   output logic syn_clr_o,
   output logic err_o
);

   localparam int unsigned CntW  = (StableN > 1) ? $clog2(StableN) : 1;
   localparam int unsigned InitW = $clog2(StableN + 3);

   typedef enum logic [2:0] {StInit, St00, St10, St11, St01} state_e;

   // Channel order in the vectors: [0]=A, [1]=B, [2]=index.
   logic [2:0]      raw;
   logic [2:0]      sync1_q, sync2_q;
   logic [2:0]      filt_q, filt_d;
   logic [CntW-1:0] cnt_q [3];
   logic [CntW-1:0] cnt_d [3];

   assign raw = {idx_i, b_i, a_i};

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         sync1_q <= '0;
         sync2_q <= '0;
         filt_q  <= '0;
         for (int i = 0; i < 3; i++) cnt_q[i] <= '0;
      end else begin
         sync1_q <= raw;
         sync2_q <= sync1_q;
         filt_q  <= filt_d;
         for (int i = 0; i < 3; i++) cnt_q[i] <= cnt_d[i];
      end
   end

   always_comb begin
      for (int i = 0; i < 3; i++) begin
         filt_d[i] = filt_q[i];
         cnt_d[i]  = '0;
         if (sync2_q[i] != filt_q[i]) begin
            if (32'(cnt_q[i]) + 32'd1 >= StableN) begin
               filt_d[i] = sync2_q[i];
            end else begin
               cnt_d[i] = cnt_q[i] + CntW'(1);
            end
         end
      end
   end

   function automatic logic [1:0] state_ab(state_e s);
      case (s)
         St10:    return 2'b10;
         St11:    return 2'b11;
         St01:    return 2'b01;
         default: return 2'b00;
      endcase
   endfunction

   function automatic state_e ab_state(logic [1:0] ab);
      case (ab)
         2'b00:   return St00;
         2'b10:   return St10;
         2'b11:   return St11;
         default: return St01;
      endcase
   endfunction

   // Successor of {A,B} in the up direction: 00 -> 10 -> 11 -> 01 -> 00.
   function automatic logic [1:0] fwd_ab(logic [1:0] ab);
      case (ab)
         2'b00:   return 2'b10;
         2'b10:   return 2'b11;
         2'b11:   return 2'b01;
         default: return 2'b00;
      endcase
   endfunction

   state_e           state_q;
   logic [InitW-1:0] init_cnt_q;
   logic             en_q, up_q, syn_clr_q, err_q, idx_prev_q;
   logic [1:0]       cur_ab, new_ab;
   logic             step_fwd, step_rev, idx_rise;

   assign cur_ab   = state_ab(state_q);
   assign new_ab   = {filt_q[0], filt_q[1]};
   assign step_fwd = (new_ab == fwd_ab(cur_ab));
   assign step_rev = (cur_ab == fwd_ab(new_ab));
   assign idx_rise = filt_q[2] & ~idx_prev_q;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q    <= StInit;
         init_cnt_q <= '0;
         en_q       <= 1'b0;
         up_q       <= 1'b1;
         syn_clr_q  <= 1'b0;
         err_q      <= 1'b0;
         idx_prev_q <= 1'b0;
      end else begin
         en_q       <= 1'b0;
         syn_clr_q  <= 1'b0;
         idx_prev_q <= filt_q[2];
         // A later err_q <= 1 in this block overrides the clear.
         if (err_clr_i) err_q <= 1'b0;
         if (state_q == StInit) begin
            init_cnt_q <= init_cnt_q + InitW'(1);
            if (32'(init_cnt_q) == StableN + 32'd2) state_q <= ab_state(new_ab);
         end else begin
            syn_clr_q <= idx_rise & en_idx_i;
            if (new_ab != cur_ab) begin
               state_q <= ab_state(new_ab);
               if (step_fwd) begin
                  en_q <= 1'b1;
                  up_q <= 1'b1;
               end else if (step_rev) begin
                  en_q <= 1'b1;
                  up_q <= 1'b0;
               end else begin
                  err_q <= 1'b1;
               end
            end
         end
      end
   end

   assign en_o      = en_q;
   assign up_o      = up_q;
   assign syn_clr_o = syn_clr_q;
   assign err_o     = err_q;

endmodule
